// File: rtl/control_pipe_unit_if.sv
// Bundle of IF/ID-side inputs and per-stage control outputs for control_pipe_unit.
// The master side drives the instruction fields; the slave side is the control unit.
interface control_pipe_unit_if #(
    parameter int OPW = 6,
    parameter int RW  = 5
);
    logic [OPW-1:0] op;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic           branch_taken;
    logic           pc_write;
    logic           if_id_write;
    logic           if_id_flush;
    logic           jump;
    logic           ex_regdst;
    logic           ex_alusrc;
    logic [1:0]     ex_aluop;
    logic           mem_branch;
    logic           mem_memread;
    logic           mem_memwrite;
    logic           wb_memtoreg;
    logic           wb_regwrite;

    modport master (
        output op, id_rs, id_rt, branch_taken,
        input  pc_write, if_id_write, if_id_flush, jump,
        input  ex_regdst, ex_alusrc, ex_aluop,
        input  mem_branch, mem_memread, mem_memwrite,
        input  wb_memtoreg, wb_regwrite
    );

    modport slave (
        input  op, id_rs, id_rt, branch_taken,
        output pc_write, if_id_write, if_id_flush, jump,
        output ex_regdst, ex_alusrc, ex_aluop,
        output mem_branch, mem_memread, mem_memwrite,
        output wb_memtoreg, wb_regwrite
    );
endinterface

// File: rtl/control_pipe_unit.sv
// Five-stage pipeline control: opcode decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall detection and branch/jump flush.
module control_pipe_unit #(
    parameter int OPW     = 6,
    parameter int RW      = 5,
    parameter bit EN_ADDI = 1'b1,
    parameter bit HAZ_EN  = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    control_pipe_unit_if.slave bus
);
    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    ctrl_t       w_dec;
    logic        w_jump_dec;
    logic        w_stall;
    logic        w_hold;
    ctrl_t       r_id_ex;
    logic [RW-1:0] r_ex_rt;
    mem_ctrl_t   r_ex_mem;
    wb_ctrl_t    r_mem_wb;

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_dec      = '0;
        w_jump_dec = 1'b0;
        case (bus.op)
            OP_R: begin
                w_dec.regdst   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = 2'b10;
            end
            OP_BEQ: begin
                w_dec.branch = 1'b1;
                w_dec.aluop  = 2'b01;
            end
            OP_LW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.memread  = 1'b1;
            end
            OP_SW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            OP_J: w_jump_dec = 1'b1;
            OP_ADDI: begin
                if (EN_ADDI) begin
                    w_dec.alusrc   = 1'b1;
                    w_dec.regwrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Load-use hazard: a load in EX whose destination feeds the instruction in ID.
    assign w_stall = HAZ_EN && r_id_ex.memread && (r_ex_rt != '0) &&
                     ((r_ex_rt == bus.id_rs) || (r_ex_rt == bus.id_rt));
    assign w_hold  = w_stall && !bus.branch_taken;

    // NOTE: pipeline state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_ex  <= '0;
            r_ex_rt  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
        end else begin
            if (bus.branch_taken || w_stall) begin
                r_id_ex <= '0;
                r_ex_rt <= '0;
            end else begin
                r_id_ex <= w_dec;
                r_ex_rt <= bus.id_rt;
            end
            if (bus.branch_taken) begin
                r_ex_mem <= '0;
            end else begin
                r_ex_mem <= '{branch:   r_id_ex.branch,
                              memread:  r_id_ex.memread,
                              memwrite: r_id_ex.memwrite,
                              memtoreg: r_id_ex.memtoreg,
                              regwrite: r_id_ex.regwrite};
            end
            r_mem_wb <= '{memtoreg: r_ex_mem.memtoreg, regwrite: r_ex_mem.regwrite};
        end
    end

    assign bus.pc_write     = !w_hold;
    assign bus.if_id_write  = !w_hold;
    assign bus.jump         = w_jump_dec && !bus.branch_taken;
    assign bus.if_id_flush  = bus.branch_taken || (w_jump_dec && !bus.branch_taken);

    assign bus.ex_regdst    = r_id_ex.regdst;
    assign bus.ex_alusrc    = r_id_ex.alusrc;
    assign bus.ex_aluop     = r_id_ex.aluop;
    assign bus.mem_branch   = r_ex_mem.branch;
    assign bus.mem_memread  = r_ex_mem.memread;
    assign bus.mem_memwrite = r_ex_mem.memwrite;
    assign bus.wb_memtoreg  = r_mem_wb.memtoreg;
    assign bus.wb_regwrite  = r_mem_wb.regwrite;
endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit: default build plus HAZ_EN=0 and EN_ADDI=0 builds
// driven with identical stimulus.
module tb_control_pipe_unit;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    control_pipe_unit_if #(.OPW(6), .RW(5)) if_a ();
    control_pipe_unit_if #(.OPW(6), .RW(5)) if_nohaz ();
    control_pipe_unit_if #(.OPW(6), .RW(5)) if_noaddi ();

    control_pipe_unit #(.OPW(6), .RW(5), .EN_ADDI(1'b1), .HAZ_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    control_pipe_unit #(.OPW(6), .RW(5), .EN_ADDI(1'b1), .HAZ_EN(1'b0)) u_dut_nohaz (
        .clk(clk), .rst_n(rst_n), .bus(if_nohaz.slave));
    control_pipe_unit #(.OPW(6), .RW(5), .EN_ADDI(1'b0), .HAZ_EN(1'b1)) u_dut_noaddi (
        .clk(clk), .rst_n(rst_n), .bus(if_noaddi.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic bt);
        if_a.op = op;       if_a.id_rs = rs;       if_a.id_rt = rt;       if_a.branch_taken = bt;
        if_nohaz.op = op;   if_nohaz.id_rs = rs;   if_nohaz.id_rt = rt;   if_nohaz.branch_taken = bt;
        if_noaddi.op = op;  if_noaddi.id_rs = rs;  if_noaddi.id_rt = rt;  if_noaddi.branch_taken = bt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ex_regdst, ex_alusrc, ex_aluop} of the default build
    function automatic logic [3:0] ex_a();
        return {if_a.ex_regdst, if_a.ex_alusrc, if_a.ex_aluop};
    endfunction

    function automatic logic [2:0] mem_a();
        return {if_a.mem_branch, if_a.mem_memread, if_a.mem_memwrite};
    endfunction

    function automatic logic [1:0] wb_a();
        return {if_a.wb_memtoreg, if_a.wb_regwrite};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(OP_R, 5'd1, 5'd2, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_pc_write", if_a.pc_write, 1'b1);
        check("rst_if_id_write", if_a.if_id_write, 1'b1);
        check("rst_flush", if_a.if_id_flush, 1'b0);
        check("rst_stages", {ex_a(), mem_a(), wb_a()}, 9'h000);

        // R-type through the pipe
        rst_n = 1'b1;
        tick();
        check("r_ex", ex_a(), 4'b1010);
        tick();
        tick();
        check("r_wb", wb_a(), 2'b01);

        // Load-use stall: lw rt=5 then R rs=5
        drive(OP_LW, 5'd0, 5'd5, 1'b0);
        check("lw_no_stall_yet", if_a.pc_write, 1'b1);
        tick();
        drive(OP_R, 5'd5, 5'd3, 1'b0);
        check("stall_pc_write", if_a.pc_write, 1'b0);
        check("stall_if_id_write", if_a.if_id_write, 1'b0);
        check("stall_no_flush", if_a.if_id_flush, 1'b0);
        check("nohaz_pc_write", if_nohaz.pc_write, 1'b1);
        tick();
        check("bubble_ex", ex_a(), 4'b0000);
        check("bubble_mem_memread", if_a.mem_memread, 1'b1);
        check("post_stall_pc_write", if_a.pc_write, 1'b1);
        check("nohaz_ex_not_bubbled", {if_nohaz.ex_regdst, if_nohaz.ex_aluop}, 3'b110);
        tick();
        check("post_stall_ex", ex_a(), 4'b1010);
        check("lw_wb", wb_a(), 2'b11);

        // lw with rt=0 never stalls
        drive(OP_LW, 5'd1, 5'd0, 1'b0);
        tick();
        drive(OP_R, 5'd0, 5'd0, 1'b0);
        check("rt0_no_stall", if_a.pc_write, 1'b1);

        // beq in EX/MEM taken while a load-use stall is pending
        drive(OP_BEQ, 5'd1, 5'd2, 1'b0);
        tick();
        drive(OP_LW, 5'd0, 5'd7, 1'b0);
        tick();
        check("beq_in_mem", if_a.mem_branch, 1'b1);
        check("lw_rt0_wb", wb_a(), 2'b11);
        drive(OP_R, 5'd7, 5'd1, 1'b1);
        check("bt_flush", if_a.if_id_flush, 1'b1);
        check("bt_pc_write", if_a.pc_write, 1'b1);
        check("bt_if_id_write", if_a.if_id_write, 1'b1);
        tick();
        check("bt_ex", ex_a(), 4'b0000);
        check("bt_mem", mem_a(), 3'b000);
        check("bt_wb", wb_a(), 2'b00);

        // Jump decode and override by branch_taken
        drive(OP_J, 5'd0, 5'd0, 1'b0);
        check("j_jump", if_a.jump, 1'b1);
        check("j_flush", if_a.if_id_flush, 1'b1);
        drive(OP_J, 5'd0, 5'd0, 1'b1);
        check("j_bt_jump", if_a.jump, 1'b0);
        check("j_bt_flush", if_a.if_id_flush, 1'b1);

        // addi enabled vs disabled
        drive(OP_ADDI, 5'd0, 5'd0, 1'b0);
        tick();
        check("addi_ex", ex_a(), 4'b0100);
        check("noaddi_ex", {if_noaddi.ex_regdst, if_noaddi.ex_alusrc, if_noaddi.ex_aluop}, 4'b0000);
        drive(OP_SW, 5'd0, 5'd0, 1'b0);
        tick();
        check("sw_ex", ex_a(), 4'b0100);
        tick();
        check("addi_wb", wb_a(), 2'b01);
        check("noaddi_wb", {if_noaddi.wb_memtoreg, if_noaddi.wb_regwrite}, 2'b00);
        check("sw_mem", mem_a(), 3'b001);

        // Reset in the middle of a load-use stall
        drive(OP_LW, 5'd0, 5'd4, 1'b0);
        tick();
        drive(OP_R, 5'd4, 5'd0, 1'b0);
        check("pre_rst_stall", if_a.pc_write, 1'b0);
        rst_n = 1'b0;
        tick();
        check("rst_stall_stages", {ex_a(), mem_a(), wb_a()}, 9'h000);
        check("rst_stall_pc_write", if_a.pc_write, 1'b1);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/control_pipe_unit.md
CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 Parameter: OPW, default 6, opcode width.
REQ-002 Parameter: RW, default 5, register-specifier width.
REQ-003 Parameter: EN_ADDI, default 1, enables addi (opcode 6'b001000) decode; when 0, addi decodes as default.
REQ-004 Parameter: HAZ_EN, default 1, enables load-use stall detection; when 0, stall is never asserted.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 op  in  OPW  opcode of instruction in IF/ID.
REQ-008 id_rs, id_rt  in  RW each  source register fields of instruction in IF/ID.
REQ-009 branch_taken  in  1  from MEM stage: mem_branch AND ALU zero, computed externally.
REQ-010 pc_write, if_id_write  out  1 each  PC and IF/ID enables, both low during stall.
REQ-011 if_id_flush  out  1  clear IF/ID to NOP next edge.
REQ-012 jump  out  1  ID-stage jump select, combinational from op.
REQ-013 ex_regdst, ex_alusrc  out  1 each; ex_aluop  out  2  EX-stage controls.
REQ-014 mem_branch, mem_memread, mem_memwrite  out  1 each  MEM-stage controls.
REQ-015 wb_memtoreg, wb_regwrite  out  1 each  WB-stage controls.

Function
REQ-016 Decode table, order RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Jump: R 6'b000000 = 1,0,0,1,0,0,0,10,0; beq 6'b000100 = 0,0,0,0,0,0,1,01,0; lw 6'b100011 = 0,1,1,1,1,0,0,00,0; sw 6'b101011 = 0,1,0,0,0,1,0,00,0; j 6'b000010 = all 0 except Jump=1; addi (EN_ADDI=1) = 0,1,0,1,0,0,0,00,0; any other opcode = all 0.
REQ-017 Control bundle SHALL be held in three registers: ID/EX (full bundle excluding Jump, plus ex_rt = id_rt), EX/MEM (MEM and WB fields), MEM/WB (WB fields).
REQ-018 Outputs ex_*, mem_*, wb_* SHALL be driven directly from ID/EX, EX/MEM, MEM/WB respectively; latency op -> ex_* = 1 cycle, -> mem_* = 2, -> wb_* = 3.
REQ-019 stall = HAZ_EN AND ID/EX.MemRead AND ex_rt != 0 AND (ex_rt == id_rs OR ex_rt == id_rt), combinational from registered state and inputs.
REQ-020 On stall (no branch_taken): pc_write=0, if_id_write=0, ID/EX loads all-zero bundle (bubble); EX/MEM and MEM/WB advance normally.
REQ-021 No stall: pc_write=1, if_id_write=1, ID/EX loads decoded bundle.
REQ-022 On branch_taken: ID/EX and EX/MEM load all-zero bundles next edge, MEM/WB advances normally, if_id_flush=1, pc_write=1, if_id_write=1.
REQ-023 branch_taken SHALL override stall in the same cycle; stall is ignored and no bubble-only hold occurs.
REQ-024 jump=1 (decoded j, no branch_taken) SHALL assert if_id_flush=1; ID/EX loads the j bundle (all zero); jump output is forced 0 when branch_taken=1.
REQ-025 Back-to-back stalls are not possible from one lw: the bubble clears ID/EX.MemRead, so stall lasts exactly 1 cycle.
REQ-026 ex_rt == 0 SHALL never cause a stall.

Reset
REQ-027 rst_n=0 at a rising edge SHALL clear ID/EX, EX/MEM, MEM/WB bundles and ex_rt to 0, overriding stall and branch_taken.
REQ-028 During and after reset with op=R: pc_write=1, if_id_write=1, if_id_flush=0, all stage outputs 0 until first post-reset edge.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abandon the operation; no state survives.

Verification
REQ-030 op=R held, 3 edges -> ex_regdst=1, ex_aluop=10 after 1 edge; wb_regwrite=1, wb_memtoreg=0 after 3 edges.
REQ-031 lw (id_rt=5) then R with id_rs=5 -> stall 1 cycle: pc_write=0, if_id_write=0, ex_* all 0 next cycle; mem_memread=1 same cycle as bubble; following cycle no stall.
REQ-032 lw with id_rt=0 then R with id_rs=0 -> no stall; HAZ_EN=0 with id_rt=5 dependency -> no stall.
REQ-033 beq in EX/MEM with branch_taken=1 while stall condition true -> if_id_flush=1, pc_write=1, ex_* and mem_* all 0 next cycle, wb_* from prior MEM/WB.
REQ-034 op=6'b000010 -> jump=1, if_id_flush=1 same cycle; op=6'b001000 with EN_ADDI=1 -> ex_alusrc=1, wb_regwrite=1 after 3 edges; EN_ADDI=0 -> all 0.
REQ-035 rst_n=0 for 1 edge during lw stall -> all stage outputs 0, pc_write=1 next cycle.
